// File: rtl/lsu_pkg.sv
// Shared LSU/data-memory definitions: MMIO register offsets, FSM encodings,
// read-source select and the bit-masked merge used by every writable word.
package lsu_pkg;

   localparam logic [3:0]  MMIO_TOHOST  = 4'h0;
   localparam logic [3:0]  MMIO_CYC_LO  = 4'h4;
   localparam logic [3:0]  MMIO_CYC_HI  = 4'h8;
   localparam logic [3:0]  MMIO_SCRATCH = 4'hC;

   localparam logic [31:0] DM_DEADBEEF  = 32'hDEAD_BEEF;
   localparam logic [31:0] DM_NO_WRITE  = 32'hFFFF_FFFF;

   localparam logic [1:0]  ST_CLEAR     = 2'd0;
   localparam logic [1:0]  ST_READY     = 2'd1;
   localparam logic [1:0]  ST_HALTED    = 2'd2;

   typedef enum logic {
      RD_SRC_REG = 1'b0,
      RD_SRC_RAM = 1'b1
   } rd_src_e;

   // Active-low per-bit mask: a 0 in mask_n takes the new data bit.
   function automatic logic [31:0] mask_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [31:0] mask_n);
      return (old_val & mask_n) | (new_val & ~mask_n);
   endfunction

endpackage

// File: rtl/dm_responder_if.sv
// LSU data-memory port: read strobe, active-low bit mask, byte address,
// lane-aligned store data and one-cycle-latency read data.
interface dm_responder_if;

   logic        DM_r_en;
   logic [31:0] DM_w_en;
   logic [31:0] DM_addr;
   logic [31:0] DM_w_data;
   logic [31:0] DM_rd_data;

   modport master (
      output DM_r_en,
      output DM_w_en,
      output DM_addr,
      output DM_w_data,
      input  DM_rd_data
   );

   modport slave (
      input  DM_r_en,
      input  DM_w_en,
      input  DM_addr,
      input  DM_w_data,
      output DM_rd_data
   );

endinterface

// File: rtl/dm_responder_sram.sv
// Single-port word SRAM with per-bit active-low write mask and a registered
// read port that holds its value when no read is requested.
module dm_sram
   import lsu_pkg::*;
#(
   parameter int DEPTH_WORDS = 4096,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wmask_n,
   input  logic [31:0]   wdata,
   input  logic          re,
   output logic [31:0]   rd_data
);

   logic [31:0] mem_r [DEPTH_WORDS];
   logic [31:0] rd_data_r;

   // Masked write and registered read share the single address port.
   always_ff @(posedge clk) begin
      if (wmask_n != DM_NO_WRITE) begin
         mem_r[addr] <= mask_merge(mem_r[addr], wdata, wmask_n);
      end
      if (re) begin
         rd_data_r <= mem_r[addr];
      end
   end

   assign rd_data = rd_data_r;

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: zero-fills the SRAM after reset, serves masked
// stores and one-cycle reads, and decodes the tohost/cycle/scratch MMIO window.
module dm_responder
   import lsu_pkg::*;
#(
   parameter int          DEPTH_WORDS = 4096,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
   input  logic           clk,
   input  logic           rst,
   dm_responder_if.slave  dm,
   output logic           init_busy,
   output logic           halt,
   output logic [31:0]    halt_code,
   output logic           err
);

   localparam int          AW       = $clog2(DEPTH_WORDS);
   localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH_WORDS - 1);

   logic [1:0]    state_r;
   logic [1:0]    state_nxt_s;
   logic [AW-1:0] clr_idx_r;
   logic          init_busy_r;
   logic [63:0]   cycle_r;
   logic [31:0]   hi_shadow_r;
   logic [31:0]   tohost_r;
   logic [31:0]   scratch_r;
   logic          halt_r;
   logic          err_r;
   rd_src_e       rd_sel_r;
   logic [31:0]   reg_rd_r;

   logic [29:0]   word_idx_s;
   logic [3:0]    mmio_off_s;
   logic          is_mmio_s;
   logic          is_ram_s;
   logic          is_wr_s;
   logic          is_rd_s;
   logic          tohost_hit_s;
   logic          scratch_hit_s;
   logic          cyc_lo_hit_s;
   logic          rd_ok_s;
   logic          wr_ok_s;
   logic [31:0]   tohost_merged_s;
   logic [31:0]   scratch_merged_s;
   logic [31:0]   mmio_rd_s;
   logic [31:0]   rd_mux_s;
   logic          addr_unused_s;

   logic [AW-1:0] sram_addr_s;
   logic [31:0]   sram_wmask_s;
   logic [31:0]   sram_wdata_s;
   logic          sram_re_s;
   logic [31:0]   sram_rd_s;

   assign word_idx_s    = dm.DM_addr[31:2];
   assign mmio_off_s    = {dm.DM_addr[3:2], 2'b00};
   assign addr_unused_s = ^dm.DM_addr[1:0];
   assign is_mmio_s     = (dm.DM_addr[31:4] == MMIO_BASE[31:4]);
   assign is_ram_s      = !is_mmio_s && (word_idx_s < 30'(DEPTH_WORDS));
   assign is_wr_s       = (dm.DM_w_en != DM_NO_WRITE);
   assign is_rd_s       = dm.DM_r_en && !is_wr_s;
   assign tohost_hit_s  = is_mmio_s && (mmio_off_s == MMIO_TOHOST);
   assign scratch_hit_s = is_mmio_s && (mmio_off_s == MMIO_SCRATCH);
   assign cyc_lo_hit_s  = is_mmio_s && (mmio_off_s == MMIO_CYC_LO);

   assign tohost_merged_s  = mask_merge(tohost_r,  dm.DM_w_data, dm.DM_w_en);
   assign scratch_merged_s = mask_merge(scratch_r, dm.DM_w_data, dm.DM_w_en);

   // FSM next state plus SRAM port steering: clear writes or the served access.
   always_comb begin
      state_nxt_s  = state_r;
      rd_ok_s      = 1'b0;
      wr_ok_s      = 1'b0;
      sram_addr_s  = word_idx_s[AW-1:0];
      sram_wdata_s = dm.DM_w_data;
      sram_wmask_s = DM_NO_WRITE;
      sram_re_s    = 1'b0;
      case (state_r)
         ST_CLEAR: begin
            sram_addr_s  = clr_idx_r;
            sram_wdata_s = 32'h0000_0000;
            sram_wmask_s = 32'h0000_0000;
            if (clr_idx_r == CLR_LAST) begin
               state_nxt_s = ST_READY;
            end else begin
               state_nxt_s = ST_CLEAR;
            end
         end
         ST_READY: begin
            rd_ok_s   = is_rd_s;
            wr_ok_s   = is_wr_s;
            sram_re_s = is_rd_s && is_ram_s;
            if (is_wr_s && is_ram_s) begin
               sram_wmask_s = dm.DM_w_en;
            end else begin
               sram_wmask_s = DM_NO_WRITE;
            end
            if (is_wr_s && tohost_hit_s && (tohost_merged_s != 32'h0000_0000)) begin
               state_nxt_s = ST_HALTED;
            end else begin
               state_nxt_s = ST_READY;
            end
         end
         ST_HALTED: begin
            rd_ok_s     = is_rd_s;
            sram_re_s   = is_rd_s && is_ram_s;
            state_nxt_s = ST_HALTED;
         end
         default: begin
            state_nxt_s = ST_CLEAR;
         end
      endcase
   end

   // MMIO read decode; unmapped offsets cannot occur but fall back to the error word.
   always_comb begin
      mmio_rd_s = DM_DEADBEEF;
      case (mmio_off_s)
         MMIO_TOHOST:  mmio_rd_s = tohost_r;
         MMIO_CYC_LO:  mmio_rd_s = cycle_r[31:0];
         MMIO_CYC_HI:  mmio_rd_s = hi_shadow_r;
         MMIO_SCRATCH: mmio_rd_s = scratch_r;
         default:      mmio_rd_s = DM_DEADBEEF;
      endcase
   end

   // State, counter, MMIO registers, sticky error and read-source capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_CLEAR;
         clr_idx_r   <= '0;
         init_busy_r <= 1'b1;
         cycle_r     <= 64'd0;
         hi_shadow_r <= 32'h0000_0000;
         tohost_r    <= 32'h0000_0000;
         scratch_r   <= 32'h0000_0000;
         halt_r      <= 1'b0;
         err_r       <= 1'b0;
         rd_sel_r    <= RD_SRC_REG;
         reg_rd_r    <= 32'h0000_0000;
      end else begin
         state_r     <= state_nxt_s;
         init_busy_r <= (state_nxt_s == ST_CLEAR);
         if (state_r == ST_CLEAR) begin
            clr_idx_r <= clr_idx_r + AW'(1);
         end
         if (state_r == ST_READY) begin
            cycle_r <= cycle_r + 64'd1;
         end
         if (wr_ok_s && tohost_hit_s) begin
            tohost_r <= tohost_merged_s;
            halt_r   <= (tohost_merged_s != 32'h0000_0000);
         end
         if (wr_ok_s && scratch_hit_s) begin
            scratch_r <= scratch_merged_s;
         end
         if (rd_ok_s && cyc_lo_hit_s) begin
            hi_shadow_r <= cycle_r[63:32];
         end
         if ((state_r != ST_CLEAR) && (is_rd_s || is_wr_s) && !is_mmio_s && !is_ram_s) begin
            err_r <= 1'b1;
         end
         // RAM data comes from the SRAM's own register; everything else is captured here.
         if (rd_ok_s) begin
            if (is_ram_s) begin
               rd_sel_r <= RD_SRC_RAM;
            end else begin
               rd_sel_r <= RD_SRC_REG;
               reg_rd_r <= is_mmio_s ? mmio_rd_s : DM_DEADBEEF;
            end
         end
      end
   end

   // Read data selects between two registered sources, both held on idle cycles.
   always_comb begin
      if (rd_sel_r == RD_SRC_RAM) begin
         rd_mux_s = sram_rd_s;
      end else begin
         rd_mux_s = reg_rd_r;
      end
   end

   dm_sram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_sram (
      .clk     (clk),
      .addr    (sram_addr_s),
      .wmask_n (sram_wmask_s),
      .wdata   (sram_wdata_s),
      .re      (sram_re_s),
      .rd_data (sram_rd_s)
   );

   assign dm.DM_rd_data = rd_mux_s;
   assign init_busy     = init_busy_r;
   assign halt          = halt_r;
   assign halt_code     = tohost_r;
   assign err           = err_r;

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder with a 16-word array: clear, masked
// stores, read latency, MMIO counter/scratch, halt and out-of-range behaviour.
module tb_dm_responder;

   localparam logic [31:0] MB = 32'hFFFF_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        init_busy;
   logic        halt;
   logic [31:0] halt_code;
   logic        err;

   dm_responder_if dm_bus ();

   dm_responder #(.DEPTH_WORDS(16), .MMIO_BASE(MB)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .dm        (dm_bus),
      .init_busy (init_busy),
      .halt      (halt),
      .halt_code (halt_code),
      .err       (err)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q  [$];
   logic [31:0] care_q [$];
   string       tag_q  [$];
   logic        pend = 1'b0;
   logic        model_run = 1'b0;
   logic [31:0] cyc_m = 32'd0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference cycle counter: counts edges while the bench believes the DUT is READY.
   always @(posedge clk) begin
      if (rst) cyc_m <= 32'd0;
      else if (model_run) cyc_m <= cyc_m + 32'd1;
   end

   always @(posedge clk) pend <= !rst && dm_bus.DM_r_en && (dm_bus.DM_w_en == 32'hFFFF_FFFF);

   // Pop one expected value per completed read, half a cycle after the edge.
   always @(negedge clk) begin
      if (pend) begin
         if (exp_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
         end else begin
            logic [31:0] e, c;
            string t;
            e = exp_q.pop_front();
            c = care_q.pop_front();
            t = tag_q.pop_front();
            check(t, dm_bus.DM_rd_data & c, e & c);
         end
      end
   end

   task automatic set_idle();
      dm_bus.DM_r_en   = 1'b0;
      dm_bus.DM_w_en   = 32'hFFFF_FFFF;
      dm_bus.DM_addr   = 32'h0;
      dm_bus.DM_w_data = 32'h0;
   endtask

   task automatic do_idle(input int n);
      set_idle();
      repeat (n) @(negedge clk);
   endtask

   task automatic do_rd(input logic [31:0] addr, input logic [31:0] exp,
                        input logic [31:0] care, input string tag);
      dm_bus.DM_r_en   = 1'b1;
      dm_bus.DM_w_en   = 32'hFFFF_FFFF;
      dm_bus.DM_addr   = addr;
      dm_bus.DM_w_data = 32'h0;
      exp_q.push_back(exp);
      care_q.push_back(care);
      tag_q.push_back(tag);
      @(negedge clk);
      set_idle();
   endtask

   task automatic do_wr(input logic [31:0] addr, input logic [31:0] data, input logic [31:0] mask_n);
      dm_bus.DM_r_en   = 1'b1;
      dm_bus.DM_w_en   = mask_n;
      dm_bus.DM_addr   = addr;
      dm_bus.DM_w_data = data;
      @(negedge clk);
      set_idle();
   endtask

   task automatic reset_and_clear(input bit probe);
      model_run = 1'b0;
      rst = 1'b1;
      set_idle();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_rd_data", dm_bus.DM_rd_data, 32'h0);
      check("rst_halt", {31'd0, halt}, 32'd0);
      check("rst_halt_code", halt_code, 32'h0);
      check("rst_err", {31'd0, err}, 32'd0);
      for (int i = 0; i < 16; i++) begin
         check("busy_during_clear", {31'd0, init_busy}, 32'd1);
         if (probe && i == 3) do_rd(32'h0, 32'h0, 32'hFFFF_FFFF, "clear_rd");
         else if (probe && i == 5) do_wr(32'h0, 32'h1234_5678, 32'h0);
         else do_idle(1);
      end
      check("busy_after_clear", {31'd0, init_busy}, 32'd0);
      model_run = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_and_clear(1'b1);
      for (int i = 0; i < 16; i++) do_rd(32'(i * 4), 32'h0, 32'hFFFF_FFFF, "zero_fill");

      // Masked store merge, then write-then-read latency and hold.
      do_wr(32'h8, 32'hAABB_CCDD, 32'h0);
      do_wr(32'h8, 32'h0000_1100, 32'hFFFF_00FF);
      do_rd(32'h8, 32'hAABB_11DD, 32'hFFFF_FFFF, "masked_store");
      do_wr(32'h4, 32'h1234_5678, 32'h0);
      do_rd(32'h4, 32'h1234_5678, 32'hFFFF_FFFF, "wr_then_rd");
      do_idle(3);
      check("rd_hold", dm_bus.DM_rd_data, 32'h1234_5678);

      // Scratch merge, RO write dropped, exact counter and shadow.
      do_wr(MB + 32'hC, 32'hCAFE_F00D, 32'h0);
      do_wr(MB + 32'hC, 32'h0000_0011, 32'hFFFF_FF00);
      do_rd(MB + 32'hC, 32'hCAFE_F011, 32'hFFFF_FFFF, "scratch");
      do_wr(MB + 32'h8, 32'hFFFF_FFFF, 32'h0);
      do_rd(MB + 32'h4, cyc_m, 32'hFFFF_FFFF, "cyc_lo");
      do_rd(MB + 32'h8, 32'h0, 32'hFFFF_FFFF, "cyc_hi");

      // Counter preloaded just below 2^32 must carry into the upper half.
      force u_dut.cycle_r = 64'h0000_0000_FFFF_FFF0;
      @(negedge clk);
      release u_dut.cycle_r;
      model_run = 1'b0;
      do_idle(30);
      do_rd(MB + 32'h4, 32'h0, 32'hFFFF_FFC0, "cyc_lo_wrapped");
      do_rd(MB + 32'h8, 32'h1, 32'hFFFF_FFFF, "cyc_hi_carry");

      // Out-of-range: error word, sticky err, no aliasing into RAM.
      do_rd(32'h40, 32'hDEAD_BEEF, 32'hFFFF_FFFF, "oor_rd");
      check("err_set", {31'd0, err}, 32'd1);
      do_wr(32'h40, 32'hFFFF_FFFF, 32'h0);
      do_rd(32'h0, 32'h0, 32'hFFFF_FFFF, "oor_no_alias");
      do_idle(2);
      check("err_sticky", {31'd0, err}, 32'd1);

      // Fresh clear, then halt behaviour with the counter modelled exactly.
      reset_and_clear(1'b0);
      do_rd(32'h4, 32'h0, 32'hFFFF_FFFF, "reclear");
      do_wr(MB, 32'h0, 32'h0);
      check("tohost_zero_no_halt", {31'd0, halt}, 32'd0);
      do_rd(MB, 32'h0, 32'hFFFF_FFFF, "tohost_zero");
      do_wr(MB, 32'h1, 32'h0);
      model_run = 1'b0;
      check("halt_set", {31'd0, halt}, 32'd1);
      check("halt_code", halt_code, 32'h1);
      do_wr(32'h8, 32'h55, 32'h0);
      do_rd(32'h8, 32'h0, 32'hFFFF_FFFF, "halt_wr_drop");
      do_wr(MB, 32'h7, 32'h0);
      check("halt_code_kept", halt_code, 32'h1);
      do_rd(MB + 32'h4, cyc_m, 32'hFFFF_FFFF, "cyc_frozen_a");
      do_idle(5);
      do_rd(MB + 32'h4, cyc_m, 32'hFFFF_FFFF, "cyc_frozen_b");
      do_idle(2);
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
